// File: rtl/seven_seg_scan_monitor_pkg.sv
// Shared constants for the seven-segment scan monitor: active-low glyphs
// ({g,f,e,d,c,b,a}) and the special digit codes reported for blank/illegal patterns.
package seven_seg_scan_monitor_pkg;

   localparam logic [6:0] GLYPH_0     = 7'b1000000;
   localparam logic [6:0] GLYPH_1     = 7'b1111001;
   localparam logic [6:0] GLYPH_2     = 7'b0100100;
   localparam logic [6:0] GLYPH_3     = 7'b0110000;
   localparam logic [6:0] GLYPH_4     = 7'b0011001;
   localparam logic [6:0] GLYPH_5     = 7'b0010010;
   localparam logic [6:0] GLYPH_6     = 7'b0000010;
   localparam logic [6:0] GLYPH_7     = 7'b1111000;
   localparam logic [6:0] GLYPH_8     = 7'b0000000;
   localparam logic [6:0] GLYPH_9     = 7'b0010000;
   localparam logic [6:0] GLYPH_BLANK = 7'b1111111;

   localparam logic [3:0] DIGIT_BLANK = 4'hF;
   localparam logic [3:0] DIGIT_BAD   = 4'hE;

endpackage

// File: rtl/seven_seg_scan_monitor_decode.sv
// Inverse seven-segment decoder: active-low segment pattern back to a digit code,
// flagging patterns that are not a legal glyph.
module seg_pattern_decode
   import seven_seg_scan_monitor_pkg::*;
(
   input  logic [6:0] segs,
   output logic [3:0] digit,
   output logic       err
);

   // NOTE: every output gets a default before the case so no path leaves it
   // unassigned; otherwise synthesis infers a latch.
   always_comb begin
      digit = DIGIT_BAD;
      err   = 1'b1;
      case (segs)
         GLYPH_0:     begin digit = 4'd0;        err = 1'b0; end
         GLYPH_1:     begin digit = 4'd1;        err = 1'b0; end
         GLYPH_2:     begin digit = 4'd2;        err = 1'b0; end
         GLYPH_3:     begin digit = 4'd3;        err = 1'b0; end
         GLYPH_4:     begin digit = 4'd4;        err = 1'b0; end
         GLYPH_5:     begin digit = 4'd5;        err = 1'b0; end
         GLYPH_6:     begin digit = 4'd6;        err = 1'b0; end
         GLYPH_7:     begin digit = 4'd7;        err = 1'b0; end
         GLYPH_8:     begin digit = 4'd8;        err = 1'b0; end
         GLYPH_9:     begin digit = 4'd9;        err = 1'b0; end
         GLYPH_BLANK: begin digit = DIGIT_BLANK; err = 1'b0; end
         default:     begin digit = DIGIT_BAD;   err = 1'b1; end
      endcase
   end

endmodule

// File: rtl/seven_seg_scan_monitor.sv
// Watches a multiplexed active-low seven-segment bus, captures each digit once its
// drive has settled, and presents complete frames with a one-cycle valid strobe.
module seven_seg_scan_monitor
   import seven_seg_scan_monitor_pkg::*;
#(
   parameter int NUM_DIGITS     = 4,
   parameter int SETTLE_CYCLES  = 4,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_DIGITS-1:0]     an,
   input  logic [6:0]                segs,
   output logic [4*NUM_DIGITS-1:0]   digits_out,
   output logic [NUM_DIGITS-1:0]     digit_err,
   output logic                      frame_valid,
   output logic                      stale
);

   localparam int STAB_W = $clog2(SETTLE_CYCLES + 1);
   localparam int TO_W   = $clog2(TIMEOUT_CYCLES + 1);

   // Capture fires on the edge the counter would step to SETTLE_CYCLES-1.
   localparam logic [STAB_W-1:0] CAPTURE_AT = STAB_W'(SETTLE_CYCLES - 2);
   localparam logic [STAB_W-1:0] STAB_MAX   = STAB_W'(SETTLE_CYCLES);
   localparam logic [TO_W-1:0]   TO_MAX     = TO_W'(TIMEOUT_CYCLES);

   typedef struct packed {
      logic [NUM_DIGITS-1:0] an;
      logic [6:0]            segs;
   } sample_t;

   sample_t                          sample;
   sample_t                          in_q;
   logic [STAB_W-1:0]                stab_cnt;
   logic [TO_W-1:0]                  to_cnt;
   logic [TO_W-1:0]                  to_nxt;
   logic [NUM_DIGITS-1:0][3:0]       slot_digit;
   logic [NUM_DIGITS-1:0][3:0]       slot_digit_nxt;
   logic [NUM_DIGITS-1:0]            slot_err;
   logic [NUM_DIGITS-1:0]            slot_err_nxt;
   logic [NUM_DIGITS-1:0]            seen;
   logic [NUM_DIGITS-1:0]            seen_nxt;
   logic [NUM_DIGITS-1:0]            sel;
   logic                             same;
   logic                             one_low;
   logic                             capture;
   logic                             frame_done;
   logic [3:0]                       dec_digit;
   logic                             dec_err;

   assign sample = {an, segs};
   assign same   = (sample == in_q);

   // Exactly one anode low; blanked or ghosted scans are never captured.
   assign sel     = ~in_q.an;
   assign one_low = (sel != '0) && ((sel & (sel - NUM_DIGITS'(1))) == '0);
   assign capture = same && (stab_cnt == CAPTURE_AT) && one_low;

   seg_pattern_decode u_decode (
      .segs  (in_q.segs),
      .digit (dec_digit),
      .err   (dec_err)
   );

   always_comb begin
      slot_digit_nxt = slot_digit;
      slot_err_nxt   = slot_err;
      seen_nxt       = seen;
      if (capture) begin
         for (int i = 0; i < NUM_DIGITS; i++) begin
            if (sel[i]) begin
               slot_digit_nxt[i] = dec_digit;
               slot_err_nxt[i]   = dec_err;
            end
         end
         seen_nxt = seen | sel;
      end
      frame_done = capture && (&seen_nxt);
      if (frame_done)
         to_nxt = '0;
      else if (to_cnt == TO_MAX)
         to_nxt = to_cnt;
      else
         to_nxt = to_cnt + TO_W'(1);
   end

   // NOTE: state is updated with non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: the slot file is small and must read back as zero after reset,
         // so it is cleared alongside the control state rather than left as-is.
         in_q        <= '1;
         stab_cnt    <= '0;
         slot_digit  <= '0;
         slot_err    <= '0;
         seen        <= '0;
         to_cnt      <= '0;
         digits_out  <= '0;
         digit_err   <= '0;
         frame_valid <= 1'b0;
         stale       <= 1'b0;
      end else begin
         in_q <= sample;
         if (!same)
            stab_cnt <= '0;
         else if (stab_cnt != STAB_MAX)
            stab_cnt <= stab_cnt + STAB_W'(1);

         slot_digit  <= slot_digit_nxt;
         slot_err    <= slot_err_nxt;
         frame_valid <= frame_done;
         if (frame_done) begin
            digits_out <= slot_digit_nxt;
            digit_err  <= slot_err_nxt;
            seen       <= '0;
         end else begin
            seen <= seen_nxt;
         end

         // A completing frame zeroes to_nxt, so it always beats a same-edge expiry.
         to_cnt <= to_nxt;
         stale  <= (to_nxt == TO_MAX);
      end
   end

endmodule

// File: tb/tb_seven_seg_scan_monitor.sv
// Directed bench for seven_seg_scan_monitor: stimulus pushes expected frames into a
// scoreboard queue, a separate monitor pops and compares on each frame_valid.
module tb_seven_seg_scan_monitor;

   localparam int ND = 4;
   localparam int SC = 4;
   localparam int TO = 50;

   logic          clk = 1'b0;
   logic          rst;
   logic [ND-1:0] an;
   logic [6:0]    segs;
   logic [4*ND-1:0] digits_out;
   logic [ND-1:0] digit_err;
   logic          frame_valid;
   logic          stale;

   typedef struct packed {
      logic [15:0] d;
      logic [3:0]  e;
   } frame_t;

   frame_t exp_q[$];
   int     n_checks = 0;
   int     n_fail   = 0;
   int     n_frames = 0;
   int     n_pushed = 0;

   always #5 clk = ~clk;

   seven_seg_scan_monitor #(
      .NUM_DIGITS     (ND),
      .SETTLE_CYCLES  (SC),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .an          (an),
      .segs        (segs),
      .digits_out  (digits_out),
      .digit_err   (digit_err),
      .frame_valid (frame_valid),
      .stale       (stale)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   function automatic logic [6:0] glyph(input int d);
      case (d)
         0: return 7'b1000000;
         1: return 7'b1111001;
         2: return 7'b0100100;
         3: return 7'b0110000;
         4: return 7'b0011001;
         5: return 7'b0010010;
         6: return 7'b0000010;
         7: return 7'b1111000;
         8: return 7'b0000000;
         9: return 7'b0010000;
         default: return 7'b1111111;
      endcase
   endfunction

   function automatic logic [ND-1:0] anode(input int i);
      logic [ND-1:0] one;
      one = ND'(1);
      return ~(one << i);
   endfunction

   task automatic push(input logic [15:0] d, input logic [3:0] e);
      exp_q.push_back('{d: d, e: e});
      n_pushed++;
   endtask

   // Inputs change on the falling edge and are held for n rising edges.
   task automatic drive(input logic [ND-1:0] a, input logic [6:0] s, input int n);
      an   = a;
      segs = s;
      repeat (n) @(negedge clk);
   endtask

   initial begin : monitor
      frame_t f;
      forever begin
         @(negedge clk);
         if (frame_valid === 1'b1) begin
            n_frames++;
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_frame: got digits %0h err %0h, expected no frame",
                        digits_out, digit_err);
            end else begin
               f = exp_q.pop_front();
               check("frame_digits", 32'(digits_out), 32'(f.d));
               check("frame_err", 32'(digit_err), 32'(f.e));
            end
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin : stimulus
      rst  = 1'b1;
      an   = '1;
      segs = '1;
      repeat (2) @(negedge clk);
      check("reset_digits", 32'(digits_out), 32'h0);
      check("reset_err", 32'(digit_err), 32'h0);
      check("reset_valid", 32'(frame_valid), 32'h0);
      check("reset_stale", 32'(stale), 32'h0);
      rst = 1'b0;

      // Basic frame
      push(16'h4321, 4'b0000);
      drive(anode(0), glyph(1), 8);
      drive(anode(1), glyph(2), 8);
      drive(anode(2), glyph(3), 8);
      drive(anode(3), glyph(4), 8);

      // Illegal and blank glyphs
      push(16'hFE65, 4'b0100);
      drive(anode(0), glyph(5), 8);
      drive(anode(1), glyph(6), 8);
      drive(anode(2), 7'b0101010, 8);
      drive(anode(3), 7'b1111111, 8);

      // Ghost and blank anodes between legal digits
      push(16'h2097, 4'b0000);
      drive(anode(0), glyph(7), 8);
      drive(4'b1100, glyph(8), 20);
      drive(anode(1), glyph(9), 8);
      drive(4'b1111, glyph(8), 20);
      drive(anode(2), glyph(0), 8);
      drive(4'b1100, glyph(1), 20);
      drive(anode(3), glyph(2), 8);

      // Settle boundary: 3-cycle dwell must not capture, 4-cycle dwell must
      drive(anode(0), glyph(0), SC - 1);
      drive('1, '1, 4);
      drive(anode(1), glyph(3), 8);
      drive(anode(2), glyph(5), 8);
      drive(anode(3), glyph(6), 8);
      drive('1, '1, 6);
      push(16'h6530, 4'b0000);
      an   = anode(0);
      segs = glyph(0);
      repeat (SC - 1) @(negedge clk);
      check("settle_before_e3", 32'(frame_valid), 32'h0);
      @(negedge clk);
      check("settle_at_e3", 32'(frame_valid), 32'h1);

      // Stop scanning: stale rises exactly TO cycles after the frame
      an   = '1;
      segs = '1;
      repeat (TO - 1) @(negedge clk);
      check("stale_before_limit", 32'(stale), 32'h0);
      @(negedge clk);
      check("stale_at_limit", 32'(stale), 32'h1);

      // Recovery: stale drops on the frame_valid edge
      push(16'h5678, 4'b0000);
      drive(anode(0), glyph(8), 8);
      drive(anode(1), glyph(7), 8);
      drive(anode(2), glyph(6), 8);
      an   = anode(3);
      segs = glyph(5);
      repeat (SC - 1) @(negedge clk);
      check("recover_stale_held", 32'(stale), 32'h1);
      check("recover_no_frame_yet", 32'(frame_valid), 32'h0);
      @(negedge clk);
      check("recover_valid", 32'(frame_valid), 32'h1);
      check("recover_stale_clear", 32'(stale), 32'h0);
      repeat (4) @(negedge clk);

      // Reset mid-frame discards the partial frame
      drive(anode(0), glyph(1), 8);
      drive(anode(1), glyph(2), 8);
      rst = 1'b1;
      @(negedge clk);
      check("midreset_digits", 32'(digits_out), 32'h0);
      check("midreset_err", 32'(digit_err), 32'h0);
      check("midreset_valid", 32'(frame_valid), 32'h0);
      check("midreset_stale", 32'(stale), 32'h0);
      rst = 1'b0;
      push(16'h4365, 4'b0000);
      drive(anode(2), glyph(3), 8);
      drive(anode(3), glyph(4), 8);
      drive(anode(0), glyph(5), 8);
      drive(anode(1), glyph(6), 8);
      drive('1, '1, 10);

      check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
      check("frame_count", 32'(n_frames), 32'(n_pushed));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
